hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl
//  Purpose  : Pipeline hazard unit for a 5-stage MIPS-style core. Detects
//             load-use and branch-operand hazards, tracks the multi-cycle
//             multiply/divide unit, and drives PC / IF/ID / ID/EX controls.
//  Ports    : clk        - rising-edge clock
//             reset      - asynchronous, active-low reset
//             Instr_ID   - instruction in ID
//             Instr_Ex   - instruction in EX
//             flush      - squash IF/ID and ID/EX this cycle
//             en_PC      - PC write enable
//             en_IF_ID   - IF/ID write enable
//             clr_IF_ID  - IF/ID synchronous clear
//             clr_ID_EX  - ID/EX clear (bubble insert)
//             md_busy    - multiply/divide unit occupied
//             md_cnt     - BUSY cycles remaining after the current one
//             stall_cnt  - saturating count of stall cycles since reset
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int MULT_CYC = 5,   // 2..15
    parameter int DIV_CYC  = 10   // 2..15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr_ID,
    input  logic [31:0] Instr_Ex,
    input  logic        flush,
    output logic        en_PC,
    output logic        en_IF_ID,
    output logic        clr_IF_ID,
    output logic        clr_ID_EX,
    output logic        md_busy,
    output logic [3:0]  md_cnt,
    output logic [15:0] stall_cnt
);

    // The op in EX is already the first busy cycle, and the BUSY state ends
    // on the cycle md_cnt reads zero, hence the "-2".
    localparam logic [3:0] c_MULT_LOAD = 4'(MULT_CYC - 2);
    localparam logic [3:0] c_DIV_LOAD  = 4'(DIV_CYC - 2);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t      r_state;
    logic [3:0]  r_md_cnt;
    logic [15:0] r_stall_cnt;

    // ------------------------------------------------------------------
    // Field decode
    // ------------------------------------------------------------------
    logic [5:0] w_op_id, w_funct_id, w_op_ex, w_funct_ex;
    logic [4:0] w_rs_id, w_rt_id, w_rt_ex, w_rd_ex;

    assign w_op_id    = Instr_ID[31:26];
    assign w_rs_id    = Instr_ID[25:21];
    assign w_rt_id    = Instr_ID[20:16];
    assign w_funct_id = Instr_ID[5:0];
    assign w_op_ex    = Instr_Ex[31:26];
    assign w_rt_ex    = Instr_Ex[20:16];
    assign w_rd_ex    = Instr_Ex[15:11];
    assign w_funct_ex = Instr_Ex[5:0];

    // Fields the hazard logic never looks at.
    logic w_unused;
    assign w_unused = ^{Instr_ID[15:6], Instr_Ex[25:21], Instr_Ex[10:6]};

    // ------------------------------------------------------------------
    // Instruction classification
    // ------------------------------------------------------------------
    logic w_rtype_id, w_rtype_ex;
    logic w_md_op_ex, w_mult_ex, w_md_op_id, w_hilo_op_id;
    logic w_load_ex, w_reads_rs, w_reads_rt, w_load_use;
    logic w_branch_id, w_br_dep;
    logic [4:0] w_dest_ex;

    assign w_rtype_id = (w_op_id == 6'h00);
    assign w_rtype_ex = (w_op_ex == 6'h00);

    assign w_md_op_ex = w_rtype_ex && (w_funct_ex inside {6'h18, 6'h19, 6'h1A, 6'h1B});
    assign w_mult_ex  = w_rtype_ex && (w_funct_ex inside {6'h18, 6'h19});
    assign w_md_op_id = w_rtype_id && (w_funct_id inside {6'h18, 6'h19, 6'h1A, 6'h1B});

    // mfhi/mthi/mflo/mtlo plus any new mult/div touch HI/LO.
    assign w_hilo_op_id = (w_rtype_id && (w_funct_id inside {6'h10, 6'h11, 6'h12, 6'h13}))
                        || w_md_op_id;

    // A load to $0 produces nothing worth waiting for.
    assign w_load_ex = (w_op_ex inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25})
                     && (w_rt_ex != 5'd0);

    // j/jal/lui and the shift-by-immediate R-types carry junk in rs.
    assign w_reads_rs = !((w_op_id inside {6'h02, 6'h03, 6'h0F})
                        || (w_rtype_id && (w_funct_id inside {6'h00, 6'h02, 6'h03})));
    assign w_reads_rt = w_rtype_id || (w_op_id inside {6'h04, 6'h05, 6'h28, 6'h29, 6'h2B});

    assign w_load_use = w_load_ex
                      && ((w_reads_rs && (w_rs_id == w_rt_ex))
                       || (w_reads_rt && (w_rt_id == w_rt_ex)));

    // Branches resolve in ID, so an ALU result still in EX cannot be
    // forwarded in time.
    assign w_branch_id = (w_op_id inside {6'h04, 6'h05})
                       || (w_rtype_id && (w_funct_id inside {6'h08, 6'h09}));

    always_comb begin
        w_dest_ex = 5'd0;
        if (w_rtype_ex && !w_md_op_ex
            && !(w_funct_ex inside {6'h08, 6'h11, 6'h13})) begin
            w_dest_ex = w_rd_ex;
        end else if (w_op_ex inside {[6'h08:6'h0F]}) begin
            w_dest_ex = w_rt_ex;
        end
    end

    assign w_br_dep = w_branch_id && (w_dest_ex != 5'd0)
                    && ((w_reads_rs && (w_rs_id == w_dest_ex))
                     || (w_reads_rt && (w_rt_id == w_dest_ex)));

    // ------------------------------------------------------------------
    // Stall / flush resolution
    // ------------------------------------------------------------------
    logic w_md_busy, w_md_stall, w_stall;

    assign w_md_busy  = (r_state == S_BUSY) || w_md_op_ex;
    assign w_md_stall = w_md_busy && w_hilo_op_id;
    assign w_stall    = w_load_use || w_br_dep || w_md_stall;

    always_comb begin
        en_PC     = 1'b1;
        en_IF_ID  = 1'b1;
        clr_IF_ID = 1'b0;
        clr_ID_EX = 1'b0;
        if (flush) begin
            clr_IF_ID = 1'b1;
            clr_ID_EX = 1'b1;
        end else if (w_stall) begin
            en_PC     = 1'b0;
            en_IF_ID  = 1'b0;
            clr_ID_EX = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Multiply/divide occupancy FSM. flush does not cancel an op that
    // has already left EX.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_md_cnt <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_md_op_ex) begin
                        r_state  <= S_BUSY;
                        r_md_cnt <= w_mult_ex ? c_MULT_LOAD : c_DIV_LOAD;
                    end
                end
                S_BUSY: begin
                    if (r_md_cnt == 4'd0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_md_cnt <= r_md_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_md_cnt <= 4'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Stall statistics (flushed cycles are not stalls)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= 16'd0;
        end else if (w_stall && !flush && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign md_busy   = w_md_busy;
    assign md_cnt    = r_md_cnt;
    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_ctrl
//  Purpose  : Self-checking bench for hazard_ctrl. Each driven cycle pushes
//             its expected outputs to a queue; a monitor pops and compares
//             them at the falling edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic [31:0] Instr_ID;
    logic [31:0] Instr_Ex;
    logic        flush;
    logic        en_PC, en_IF_ID, clr_IF_ID, clr_ID_EX, md_busy;
    logic [3:0]  md_cnt;
    logic [15:0] stall_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // {en_PC, en_IF_ID, clr_IF_ID, clr_ID_EX}
    localparam logic [3:0] c_RUN   = 4'b1100;
    localparam logic [3:0] c_STALL = 4'b0001;
    localparam logic [3:0] c_FLUSH = 4'b1111;

    // Instruction encodings
    localparam logic [31:0] c_NOP      = 32'h0;
    localparam logic [31:0] c_LW_8_9   = {6'h23, 5'd9, 5'd8, 16'd0};
    localparam logic [31:0] c_LW_0_9   = {6'h23, 5'd9, 5'd0, 16'd0};
    localparam logic [31:0] c_ADD_10_8 = {6'h00, 5'd8, 5'd11, 5'd10, 5'd0, 6'h20};
    localparam logic [31:0] c_ADD_10_0 = {6'h00, 5'd0, 5'd0, 5'd10, 5'd0, 6'h20};
    localparam logic [31:0] c_ADD_31   = {6'h00, 5'd1, 5'd2, 5'd31, 5'd0, 6'h20};
    localparam logic [31:0] c_LUI_8    = {6'h0F, 5'd0, 5'd8, 16'h1234};
    localparam logic [31:0] c_ADDI_8   = {6'h08, 5'd9, 5'd8, 16'd1};
    localparam logic [31:0] c_BEQ_8    = {6'h04, 5'd8, 5'd0, 16'd4};
    localparam logic [31:0] c_JR_31    = {6'h00, 5'd31, 15'd0, 6'h08};
    localparam logic [31:0] c_MULT     = {6'h00, 5'd4, 5'd5, 10'd0, 6'h18};
    localparam logic [31:0] c_DIV      = {6'h00, 5'd4, 5'd5, 10'd0, 6'h1A};
    localparam logic [31:0] c_MFHI     = {6'h00, 10'd0, 5'd2, 5'd0, 6'h10};
    localparam logic [31:0] c_MFLO     = {6'h00, 10'd0, 5'd2, 5'd0, 6'h12};

    typedef struct {
        string       tag;
        logic [3:0]  ctrl;
        logic        busy;
        logic [3:0]  cnt;
        logic [15:0] sc;
    } exp_t;

    exp_t exp_q[$];

    hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .Instr_ID  (Instr_ID),
        .Instr_Ex  (Instr_Ex),
        .flush     (flush),
        .en_PC     (en_PC),
        .en_IF_ID  (en_IF_ID),
        .clr_IF_ID (clr_IF_ID),
        .clr_ID_EX (clr_ID_EX),
        .md_busy   (md_busy),
        .md_cnt    (md_cnt),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: compare every queued expectation at the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_val({e.tag, ".ctrl"}, {28'd0, en_PC, en_IF_ID, clr_IF_ID, clr_ID_EX}, {28'd0, e.ctrl});
                check_val({e.tag, ".busy"}, {31'd0, md_busy}, {31'd0, e.busy});
                check_val({e.tag, ".cnt"},  {28'd0, md_cnt},  {28'd0, e.cnt});
                check_val({e.tag, ".sc"},   {16'd0, stall_cnt}, {16'd0, e.sc});
            end
        end
    end

    // Drive one cycle (called at posedge+1) and queue its expected outputs.
    task automatic step(input string tag, input logic [31:0] id, input logic [31:0] ex,
                        input logic fl, input logic [3:0] ctrl, input logic busy,
                        input logic [3:0] cnt, input logic [15:0] sc);
        exp_t e;
        Instr_ID = id;
        Instr_Ex = ex;
        flush    = fl;
        e.tag = tag; e.ctrl = ctrl; e.busy = busy; e.cnt = cnt; e.sc = sc;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b0;
        Instr_ID = c_NOP;
        Instr_Ex = c_NOP;
        flush    = 1'b0;
        @(posedge clk); #1;
        step("reset", c_NOP, c_NOP, 1'b0, c_RUN, 1'b0, 4'd0, 16'd0);
        reset = 1'b1;
        step("post_reset", c_NOP, c_NOP, 1'b0, c_RUN, 1'b0, 4'd0, 16'd0);

        // Load-use and false-hazard cases
        step("ld_use",     c_ADD_10_8, c_LW_8_9, 1'b0, c_STALL, 1'b0, 4'd0, 16'd0);
        step("ld_release", c_ADD_10_8, c_NOP,    1'b0, c_RUN,   1'b0, 4'd0, 16'd1);
        step("ld_r0",      c_ADD_10_0, c_LW_0_9, 1'b0, c_RUN,   1'b0, 4'd0, 16'd1);
        step("ld_lui",     c_LUI_8,    c_LW_8_9, 1'b0, c_RUN,   1'b0, 4'd0, 16'd1);

        // Branch operand hazards
        step("br_beq",     c_BEQ_8,    c_ADDI_8, 1'b0, c_STALL, 1'b0, 4'd0, 16'd1);
        step("br_release", c_BEQ_8,    c_NOP,    1'b0, c_RUN,   1'b0, 4'd0, 16'd2);
        step("br_jr",      c_JR_31,    c_ADD_31, 1'b0, c_STALL, 1'b0, 4'd0, 16'd2);
        step("alu_fwd",    c_ADD_10_8, c_ADDI_8, 1'b0, c_RUN,   1'b0, 4'd0, 16'd3);

        // Flush wins over stall and is not counted
        step("flush_ld",   c_ADD_10_8, c_LW_8_9, 1'b1, c_FLUSH, 1'b0, 4'd0, 16'd3);
        step("flush_after", c_NOP,     c_NOP,    1'b0, c_RUN,   1'b0, 4'd0, 16'd3);

        // mult: 5 stalled cycles for mfhi, released on the 6th
        step("mult0", c_MFHI, c_MULT, 1'b0, c_STALL, 1'b1, 4'd0, 16'd3);
        for (int i = 1; i < 5; i++)
            step("mult", c_MFHI, c_NOP, 1'b0, c_STALL, 1'b1, 4'(4 - i), 16'(3 + i));
        step("mult_done", c_MFHI, c_NOP, 1'b0, c_RUN, 1'b0, 4'd0, 16'd8);

        // div: 10 stalled cycles for mflo
        step("div0", c_MFLO, c_DIV, 1'b0, c_STALL, 1'b1, 4'd0, 16'd8);
        for (int i = 1; i < 10; i++)
            step("div", c_MFLO, c_NOP, 1'b0, c_STALL, 1'b1, 4'(9 - i), 16'(8 + i));
        step("div_done", c_MFLO, c_NOP, 1'b0, c_RUN, 1'b0, 4'd0, 16'd18);

        // flush during BUSY keeps the counter running
        step("mf_start", c_NOP,  c_MULT, 1'b0, c_RUN,   1'b1, 4'd0, 16'd18);
        step("mf_flush", c_NOP,  c_NOP,  1'b1, c_FLUSH, 1'b1, 4'd3, 16'd18);
        step("mf_hold2", c_MFHI, c_NOP,  1'b0, c_STALL, 1'b1, 4'd2, 16'd18);
        step("mf_hold1", c_MFHI, c_NOP,  1'b0, c_STALL, 1'b1, 4'd1, 16'd19);
        step("mf_hold0", c_MFHI, c_NOP,  1'b0, c_STALL, 1'b1, 4'd0, 16'd20);
        step("mf_done",  c_MFHI, c_NOP,  1'b0, c_RUN,   1'b0, 4'd0, 16'd21);

        // Asynchronous reset in the middle of a divide
        step("rd_start", c_NOP, c_DIV, 1'b0, c_RUN, 1'b1, 4'd0, 16'd21);
        step("rd_busy1", c_NOP, c_NOP, 1'b0, c_RUN, 1'b1, 4'd8, 16'd21);
        step("rd_busy2", c_NOP, c_NOP, 1'b0, c_RUN, 1'b1, 4'd7, 16'd21);
        #2;
        reset = 1'b0;
        #1;
        check_val("async_rst.busy", {31'd0, md_busy}, 32'd0);
        check_val("async_rst.cnt",  {28'd0, md_cnt}, 32'd0);
        check_val("async_rst.sc",   {16'd0, stall_cnt}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        step("rst_mflo", c_MFLO, c_NOP, 1'b0, c_RUN, 1'b0, 4'd0, 16'd0);

        // Saturation: hold a load-use stall for 65540 cycles in total
        Instr_ID = c_ADD_10_8;
        Instr_Ex = c_LW_8_9;
        flush    = 1'b0;
        repeat (65534) @(posedge clk);
        #1;
        step("sat_fffe", c_ADD_10_8, c_LW_8_9, 1'b0, c_STALL, 1'b0, 4'd0, 16'hFFFE);
        step("sat_ffff", c_ADD_10_8, c_LW_8_9, 1'b0, c_STALL, 1'b0, 4'd0, 16'hFFFF);
        step("sat_hold", c_ADD_10_8, c_LW_8_9, 1'b0, c_STALL, 1'b0, 4'd0, 16'hFFFF);
        repeat (3) @(posedge clk);
        #1;
        check_val("sat_final", {16'd0, stall_cnt}, 32'h0000FFFF);

        Instr_ID = c_NOP;
        Instr_Ex = c_NOP;
        @(negedge clk);
        check_val("queue_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
